// File: rtl/feedback_tx_pkg.sv
// Shared link definitions for the FPGA<->mbed bit-handshake link.
// The instruction receiver uses the same word width, so both ends shift the same word size.
package feedback_tx_pkg;

    localparam int LINK_WIDTH      = 10;
    localparam int DEFAULT_TIMEOUT = 4095;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_REQ = 3'd1,
        PRESENT  = 3'd2,
        WAIT_REL = 3'd3,
        SHIFT    = 3'd4,
        DONE     = 3'd5
    } tx_state_t;

    // The timeout counter only runs in these two states.
    // In both of them the FSM is waiting for the mbed.
    function automatic logic is_waiting(input tx_state_t s);
        return (s == WAIT_REQ) || (s == WAIT_REL);
    endfunction

endpackage

// File: rtl/feedback_tx_if.sv
// Bit-handshake signals between the FPGA transmitter (master) and the mbed (slave).
interface feedback_tx_if;
    logic bit_request;
    logic data_bit;
    logic bit_valid;

    modport master (input bit_request, output data_bit, output bit_valid);
    modport slave  (output bit_request, input data_bit, input bit_valid);
endinterface

// File: rtl/feedback_tx_sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous input.
// The flops reset low.
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/feedback_tx.sv
// Serial feedback transmitter that sends a parallel status word MSB-first to the mbed.
// It sends one bit per four-phase request/confirm handshake.
module feedback_tx
    import feedback_tx_pkg::*;
#(
    parameter int WIDTH   = LINK_WIDTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic             abort,
    feedback_tx_if.master    link,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [3:0]       bit_count,
    output logic [2:0]       state
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    tx_state_t        cur_state, nxt_state;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [3:0]       count_nxt;
    logic [TW-1:0]    tmr, tmr_nxt;
    logic             req_s;
    logic             tmo_hit;
    logic             data_bit_q, data_bit_nxt;
    logic             bit_valid_q, bit_valid_nxt;
    logic             busy_nxt, done_nxt, tmo_nxt;

    sync_2ff u_req_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (link.bit_request),
        .q       (req_s)
    );

    assign tmo_hit = (TIMEOUT != 0) && (tmr == TW'(TIMEOUT - 1));

    // Outputs are decoded from the next state, so every output is a flop.
    // Outputs also change on the same edge as the state.
    always_comb begin
        nxt_state = cur_state;
        shreg_nxt = shreg;
        count_nxt = bit_count;
        tmo_nxt   = 1'b0;

        if (abort) begin
            nxt_state = IDLE;
        end else begin
            case (cur_state)
                IDLE: begin
                    if (load) begin
                        shreg_nxt = word;
                        count_nxt = 4'd0;
                        nxt_state = WAIT_REQ;
                    end
                end
                WAIT_REQ: begin
                    if (req_s) begin
                        nxt_state = PRESENT;
                    end else if (tmo_hit) begin
                        nxt_state = IDLE;
                        tmo_nxt   = 1'b1;
                    end
                end
                PRESENT: nxt_state = WAIT_REL;
                WAIT_REL: begin
                    if (!req_s) begin
                        nxt_state = SHIFT;
                    end else if (tmo_hit) begin
                        nxt_state = IDLE;
                        tmo_nxt   = 1'b1;
                    end
                end
                SHIFT: begin
                    shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
                    if (bit_count != 4'(WIDTH))
                        count_nxt = bit_count + 4'd1;
                    nxt_state = (bit_count + 4'd1 == 4'(WIDTH)) ? DONE : WAIT_REQ;
                end
                DONE:    nxt_state = IDLE;
                default: nxt_state = IDLE;
            endcase
        end

        busy_nxt      = (nxt_state != IDLE);
        done_nxt      = (nxt_state == DONE);
        bit_valid_nxt = (nxt_state == PRESENT) || (nxt_state == WAIT_REL);
        data_bit_nxt  = (nxt_state == IDLE) ? 1'b0 : shreg_nxt[WIDTH-1];

        if (nxt_state != cur_state)
            tmr_nxt = '0;
        else if (is_waiting(cur_state))
            tmr_nxt = tmr + 1'b1;
        else
            tmr_nxt = tmr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state   <= IDLE;
            shreg       <= '0;
            bit_count   <= 4'd0;
            tmr         <= '0;
            data_bit_q  <= 1'b0;
            bit_valid_q <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            cur_state   <= nxt_state;
            shreg       <= shreg_nxt;
            bit_count   <= count_nxt;
            tmr         <= tmr_nxt;
            data_bit_q  <= data_bit_nxt;
            bit_valid_q <= bit_valid_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            timeout_err <= tmo_nxt;
        end
    end

    assign link.data_bit  = data_bit_q;
    assign link.bit_valid = bit_valid_q;
    assign state          = cur_state;

endmodule

// File: tb/tb_feedback_tx.sv
// Directed and randomized bench for feedback_tx with an mbed-side handshake model.
// The reference model treats a word as its bit list sent MSB-first.
module tb_feedback_tx;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;

    logic       load = 1'b0;
    logic       abort = 1'b0;
    logic [9:0] word = '0;
    logic       busy, done, timeout_err;
    logic [3:0] bit_count;
    logic [2:0] state;

    logic       load_to = 1'b0;
    logic       abort_to = 1'b0;
    logic [9:0] word_to = '0;
    logic       busy_to, done_to, timeout_err_to;
    logic [3:0] bit_count_to;
    logic [2:0] state_to;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int to_cnt = 0;
    int vr_cnt = 0;
    int done_to_cnt = 0;
    logic vld_prev = 1'b0;

    feedback_tx_if link ();
    feedback_tx_if link_to ();

    feedback_tx dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (load),
        .word        (word),
        .abort       (abort),
        .link        (link),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .bit_count   (bit_count),
        .state       (state)
    );

    feedback_tx #(.TIMEOUT(16)) dut_to (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (load_to),
        .word        (word_to),
        .abort       (abort_to),
        .link        (link_to),
        .busy        (busy_to),
        .done        (done_to),
        .timeout_err (timeout_err_to),
        .bit_count   (bit_count_to),
        .state       (state_to)
    );

    always #5 clk = ~clk;

    // Event counters shared by the directed steps below.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (timeout_err === 1'b1) to_cnt++;
        if (done_to === 1'b1) done_to_cnt++;
        if (link.bit_valid === 1'b1 && vld_prev !== 1'b1) vr_cnt++;
        vld_prev = link.bit_valid;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [9:0] w);
        word = w;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic gap();
        repeat ($urandom_range(20, 0)) @(negedge clk);
    endtask

    task automatic waitValid(input logic lvl, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (link.bit_valid === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic waitDone(output logic ok);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // mbed model: request, capture the bit on confirm, release, wait for confirm to drop.
    task automatic receiveBits(input int n, output logic [9:0] bits);
        logic ok;
        bits = '0;
        for (int i = 0; i < n; i++) begin
            gap();
            link.bit_request = 1'b1;
            waitValid(1'b1, ok);
            checkOutput("confirm_rise", {31'd0, ok}, 32'd1);
            bits = {bits[8:0], link.data_bit};
            gap();
            link.bit_request = 1'b0;
            waitValid(1'b0, ok);
            checkOutput("confirm_fall", {31'd0, ok}, 32'd1);
        end
    endtask

    initial begin
        logic [9:0] got, got2, w;
        logic       ok, first;
        int         base, base_to, fire_at;

        link.bit_request    = 1'b0;
        link_to.bit_request = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_state", {29'd0, state}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_valid", {31'd0, link.bit_valid}, 32'd0);
        checkOutput("rst_data", {31'd0, link.data_bit}, 32'd0);
        checkOutput("rst_count", {28'd0, bit_count}, 32'd0);
        checkOutput("rst_done_tmo", {30'd0, done, timeout_err}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Nominal word
        w = 10'b1011001110;
        base = done_cnt;
        applyStimulus(w);
        checkOutput("load_busy", {31'd0, busy}, 32'd1);
        checkOutput("load_first_bit", {31'd0, link.data_bit}, {31'd0, w[9]});
        receiveBits(10, got);
        checkOutput("nominal_bits", {22'd0, got}, {22'd0, w});
        waitDone(ok);
        checkOutput("nominal_done_seen", {31'd0, ok}, 32'd1);
        @(negedge clk);
        checkOutput("nominal_busy_after", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("nominal_done_once", done_cnt - base, 32'd1);
        checkOutput("nominal_count", {28'd0, bit_count}, 32'd10);

        // Back-to-back words with an ignored load mid-word
        base = done_cnt;
        applyStimulus(10'h3FF);
        receiveBits(2, got);
        applyStimulus(10'h155);
        receiveBits(8, got2);
        checkOutput("b2b_word1", {22'd0, got[1:0], got2[7:0]}, 32'h3FF);
        waitDone(ok);
        checkOutput("b2b_done1", {31'd0, ok}, 32'd1);
        @(negedge clk);
        applyStimulus(10'h000);
        checkOutput("b2b_reload_busy", {31'd0, busy}, 32'd1);
        checkOutput("b2b_reload_count", {28'd0, bit_count}, 32'd0);
        receiveBits(10, got);
        checkOutput("b2b_word2", {22'd0, got}, 32'h000);
        waitDone(ok);
        repeat (3) @(negedge clk);
        checkOutput("b2b_done_count", done_cnt - base, 32'd2);

        // Randomized words
        for (int k = 0; k < 4; k++) begin
            w = 10'($urandom);
            applyStimulus(w);
            receiveBits(10, got);
            checkOutput("rand_word", {22'd0, got}, {22'd0, w});
            waitDone(ok);
            checkOutput("rand_done", {31'd0, ok}, 32'd1);
            @(negedge clk);
        end

        // Sticky request: one confirm, then wait for release and a fresh request
        w = 10'($urandom);
        applyStimulus(w);
        base = vr_cnt;
        link.bit_request = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("sticky_pulses", vr_cnt - base, 32'd1);
        checkOutput("sticky_held", {31'd0, link.bit_valid}, 32'd1);
        first = link.data_bit;
        link.bit_request = 1'b0;
        waitValid(1'b0, ok);
        checkOutput("sticky_release", {31'd0, ok}, 32'd1);
        repeat (10) @(negedge clk);
        checkOutput("sticky_no_rerequest", {31'd0, link.bit_valid}, 32'd0);
        checkOutput("sticky_count", {28'd0, bit_count}, 32'd1);
        receiveBits(9, got);
        checkOutput("sticky_word", {22'd0, first, got[8:0]}, {22'd0, w});
        waitDone(ok);
        @(negedge clk);

        // Reset mid-word
        w = 10'h2A5;
        applyStimulus(w);
        receiveBits(3, got);
        checkOutput("midrst_first3", {29'd0, got[2:0]}, {29'd0, w[9:7]});
        link.bit_request = 1'b1;
        waitValid(1'b1, ok);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midrst_valid", {31'd0, link.bit_valid}, 32'd0);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst_state", {29'd0, state}, 32'd0);
        checkOutput("midrst_count", {28'd0, bit_count}, 32'd0);
        checkOutput("midrst_data", {31'd0, link.data_bit}, 32'd0);
        link.bit_request = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        applyStimulus(10'h001);
        receiveBits(10, got);
        checkOutput("midrst_reload_word", {22'd0, got}, 32'h001);
        waitDone(ok);
        @(negedge clk);

        // Abort during bit 5 confirm, then load+abort together in IDLE
        base = done_cnt;
        base_to = to_cnt;
        applyStimulus(10'($urandom));
        receiveBits(4, got);
        link.bit_request = 1'b1;
        waitValid(1'b1, ok);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_valid", {31'd0, link.bit_valid}, 32'd0);
        checkOutput("abort_state", {29'd0, state}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        link.bit_request = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("abort_no_done", done_cnt - base, 32'd0);
        checkOutput("abort_no_tmo", to_cnt - base_to, 32'd0);
        checkOutput("abort_count_kept", {28'd0, bit_count}, 32'd4);
        word = 10'h3FF;
        load = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        load = 1'b0;
        abort = 1'b0;
        checkOutput("ldabort_busy", {31'd0, busy}, 32'd0);
        checkOutput("ldabort_state", {29'd0, state}, 32'd0);
        @(negedge clk);
        checkOutput("ldabort_count", {28'd0, bit_count}, 32'd4);

        // Timeout on the TIMEOUT=16 instance with no request
        word_to = 10'h1C3;
        load_to = 1'b1;
        @(negedge clk);
        load_to = 1'b0;
        checkOutput("tmo_busy_start", {31'd0, busy_to}, 32'd1);
        fire_at = -1;
        base = 0;
        for (int j = 1; j <= 40; j++) begin
            if (timeout_err_to === 1'b1) begin
                base++;
                if (fire_at < 0) begin
                    fire_at = j;
                    checkOutput("tmo_busy_at_fire", {31'd0, busy_to}, 32'd0);
                end
            end
            @(negedge clk);
        end
        checkOutput("tmo_fire_cycle", fire_at, 32'd17);
        checkOutput("tmo_pulse_width", base, 32'd1);
        checkOutput("tmo_no_done", done_to_cnt, 32'd0);
        checkOutput("tmo_idle", {29'd0, state_to}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
